// File: rtl/ama_riscv_mem_req_ctrl_pkg.sv
// Shared defines for the data-cache memory request controller:
// bus widths, timeout default and the controller state type.
package ama_riscv_mem_req_ctrl_pkg;

  localparam int unsigned MEM_ADDR_BUS        = 32;
  localparam int unsigned MEM_DATA_BUS        = 128;
  localparam int unsigned MEM_TIMEOUT_CYC_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD,
    RD_WAIT,
    REFILL
  } mem_req_state_t;

endpackage

// File: rtl/ama_riscv_rv_if.sv
// Valid/ready channel interfaces used between the cache side and the line
// memory: rv_if carries a single data payload, rv_if_da carries addr + wdata.
interface rv_if #(
  parameter int unsigned W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport TX (output valid, output data, input ready);
  modport RX (input valid, input data, output ready);
endinterface

interface rv_if_da #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 128
);
  logic          valid;
  logic          ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  modport TX (output valid, output addr, output wdata, input ready);
  modport RX (input valid, input addr, input wdata, output ready);
endinterface

// File: rtl/ama_riscv_mem_req_timer.sv
// Read-response timeout counter. Counts cycles while run is high, returns to
// zero whenever run drops, saturates at CYC. expired flags the cycle in which
// the count would reach CYC, so the controller can leave on that same edge.
module ama_riscv_mem_req_timer #(
  parameter int unsigned CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = $clog2(CYC + 1);

  logic [CW-1:0] cnt;

  // Saturating cycle counter, cleared outside the waiting window
  always_ff @(posedge clk) begin
    if (rst || !run) cnt <= '0;
    else if (cnt != CW'(CYC)) cnt <= cnt + 1'b1;
  end

  assign expired = run && (cnt == CW'(CYC - 1));

endmodule

// File: rtl/ama_riscv_mem_req_ctrl.sv
// Line-level memory initiator between the data cache and the line memory.
// One miss at a time: optional dirty-victim writeback, then the line read,
// then a valid/ready refill back to the cache.
// Optional feature: AMA_RISCV_MEM_TIMEOUT_EN adds a read-response timeout
// with a sticky timeout_err flag (tied 0 when the macro is not defined).

`ifndef DFF_CI_RI_RVI
`define DFF_CI_RI_RVI(rv, d, q) always_ff @(posedge clk) begin if (rst) q <= rv; else q <= d; end
`endif
`ifndef DFF_CI_RI_RVI_EN
`define DFF_CI_RI_RVI_EN(rv, d, q, en) always_ff @(posedge clk) begin if (rst) q <= rv; else if (en) q <= d; end
`endif

module ama_riscv_mem_req_ctrl
  import ama_riscv_mem_req_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT_CYC = MEM_TIMEOUT_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_valid,
  output logic                    miss_ready,
  input  logic [MEM_ADDR_BUS-1:0] miss_addr,
  input  logic                    miss_wb,
  input  logic [MEM_ADDR_BUS-1:0] miss_wb_addr,
  input  logic [MEM_DATA_BUS-1:0] miss_wb_data,
  output logic                    refill_valid,
  input  logic                    refill_ready,
  output logic [MEM_DATA_BUS-1:0] refill_data,
  output logic [MEM_ADDR_BUS-1:0] refill_addr,
  rv_if.TX                        req_dmem_r,
  rv_if_da.TX                     req_dmem_w,
  rv_if.RX                        rsp_dmem,
  output logic                    timeout_err
);

  mem_req_state_t state, state_nx;

  logic                    miss_acc;
  logic                    rd_timeout;
  logic                    line_cap;
  logic [MEM_DATA_BUS-1:0] line_nx;
  logic [MEM_ADDR_BUS-1:0] miss_addr_q;
  logic [MEM_ADDR_BUS-1:0] wb_addr_q;
  logic [MEM_DATA_BUS-1:0] wb_data_q;

  // Next state and state-decoded handshake outputs; the dirty flag is consumed
  // at acceptance by choosing WB or RD, so the state itself remembers it
  always_comb begin
    state_nx         = state;
    miss_ready       = 1'b0;
    req_dmem_w.valid = 1'b0;
    req_dmem_r.valid = 1'b0;
    rsp_dmem.ready   = 1'b0;
    refill_valid     = 1'b0;
    case (state)
      IDLE: begin
        miss_ready = !rst;
        if (miss_valid) state_nx = miss_wb ? WB : RD;
      end
      WB: begin
        req_dmem_w.valid = 1'b1;
        if (req_dmem_w.ready) state_nx = RD;
      end
      RD: begin
        req_dmem_r.valid = 1'b1;
        if (req_dmem_r.ready) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        rsp_dmem.ready = 1'b1;
        if (rsp_dmem.valid || rd_timeout) state_nx = REFILL;
      end
      REFILL: begin
        refill_valid = 1'b1;
        if (refill_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign miss_acc = (state == IDLE) && miss_valid;
  assign line_cap = (state == RD_WAIT) && (rsp_dmem.valid || rd_timeout);
  assign line_nx  = rsp_dmem.valid ? rsp_dmem.data : '0;

  // State register
  `DFF_CI_RI_RVI(IDLE, state_nx, state)

  // Request fields captured at acceptance, stable until the refill leaves
  `DFF_CI_RI_RVI_EN('0, miss_addr, miss_addr_q, miss_acc)
  // Victim address captured at acceptance
  `DFF_CI_RI_RVI_EN('0, miss_wb_addr, wb_addr_q, miss_acc)
  // Victim data captured at acceptance
  `DFF_CI_RI_RVI_EN('0, miss_wb_data, wb_data_q, miss_acc)

  // Returned line (or zero on timeout) held for the cache during REFILL
  `DFF_CI_RI_RVI_EN('0, line_nx, refill_data, line_cap)

  assign req_dmem_r.data  = miss_addr_q;
  assign req_dmem_w.addr  = wb_addr_q;
  assign req_dmem_w.wdata = wb_data_q;
  assign refill_addr      = miss_addr_q;

`ifdef AMA_RISCV_MEM_TIMEOUT_EN
  logic timer_expired;

  ama_riscv_mem_req_timer #(
    .CYC (MEM_TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (state == RD_WAIT),
    .expired (timer_expired)
  );

  // A response arriving in the expiry cycle still wins over the timeout
  assign rd_timeout = timer_expired && !rsp_dmem.valid;

  // Sticky timeout flag, only cleared by reset
  `DFF_CI_RI_RVI_EN(1'b0, 1'b1, timeout_err, rd_timeout)
`else
  logic [$clog2(MEM_TIMEOUT_CYC + 1)-1:0] timer_unused;

  assign timer_unused = '0;
  assign rd_timeout   = 1'b0;
  assign timeout_err  = 1'b0;
`endif

endmodule
